// File: rtl/typedefs_pkg.sv
// typedefs_pkg: shared colour and player-state types for the Genius game
package typedefs_pkg;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, YELLOW = 2'd3} color_t;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ON, GAP, DONE} player_state_t;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/led_decoder.sv
// led_decoder: colour code plus enable to one-hot LED drive
module led_decoder
  import typedefs_pkg::*;
(
  input  color_t color,
  input  logic   en,
  output logic   red,
  output logic   green,
  output logic   blue,
  output logic   yellow
);
  assign red    = en && color == RED;
  assign green  = en && color == GREEN;
  assign blue   = en && color == BLUE;
  assign yellow = en && color == YELLOW;
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays the stored colour sequence on the LEDs, lit time then dark gap per item
module sequence_player
  import typedefs_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 2,
  parameter int FAST_TICKS = 25_000_000,
  parameter int SLOW_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] last_index,
  input  logic                  speed,
  input  logic                  all_leds,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  led_red,
  output logic                  led_green,
  output logic                  led_blue,
  output logic                  led_yellow
);
  localparam int TW = $clog2(max3(FAST_TICKS, SLOW_TICKS, GAP_TICKS) + 1);
  player_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] idx, last_q;
  logic speed_q;
  logic [TW-1:0] timer;
  color_t color;
  logic t_end, dec_red, dec_green, dec_blue, dec_yellow, idle_all;
  assign t_end = timer == '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FETCH : IDLE;
      FETCH:   state_n = LATCH;
      LATCH:   state_n = ON;
      ON:      state_n = t_end ? GAP : ON;
      GAP:     state_n = !t_end ? GAP : (idx == last_q ? DONE : FETCH);
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      last_q  <= '0;
      speed_q <= 1'b0;
      timer   <= '0;
      color   <= RED;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        idx     <= '0;
        last_q  <= last_index;
        speed_q <= speed;
      end
      if (state == GAP && t_end && idx != last_q) idx <= idx + 1'b1;
      if (state == LATCH) color <= color_t'(mem_data[1:0]);
      // one down-counter shared by the lit and dark phases, loaded with N-1 on entry
      if (state == LATCH) timer <= speed_q ? TW'(FAST_TICKS - 1) : TW'(SLOW_TICKS - 1);
      else if (state == ON && t_end) timer <= TW'(GAP_TICKS - 1);
      else if (!t_end) timer <= timer - 1'b1;
    end
  end
  led_decoder u_dec (
    .color (color),
    .en    (state == ON),
    .red   (dec_red),
    .green (dec_green),
    .blue  (dec_blue),
    .yellow(dec_yellow)
  );
  assign idle_all   = state == IDLE && all_leds && rst_n;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign mem_rd     = state == FETCH;
  assign mem_addr   = state == FETCH ? idx : '0;
  assign led_red    = dec_red || idle_all;
  assign led_green  = dec_green || idle_all;
  assign led_blue   = dec_blue || idle_all;
  assign led_yellow = dec_yellow || idle_all;
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: cycle-exact comparison of playback against a per-cycle schedule model
module tb_sequence_player;
  localparam int FAST = 4, SLOW = 8, GAPT = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, speed = 1'b0, all_leds = 1'b0;
  logic [4:0] last_index = '0;
  logic mem_rd, busy, done, led_red, led_green, led_blue, led_yellow;
  logic [4:0] mem_addr;
  logic [1:0] mem_data = '0;
  logic [1:0] mem [32];
  int tests = 0, fails = 0;
  wire [11:0] obs = {busy, done, mem_rd, mem_addr, led_yellow, led_blue, led_green, led_red};

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  sequence_player #(
    .ADDR_WIDTH(5), .DATA_WIDTH(2), .FAST_TICKS(FAST), .SLOW_TICKS(SLOW), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_index(last_index), .speed(speed),
    .all_leds(all_leds), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .led_red(led_red), .led_green(led_green),
    .led_blue(led_blue), .led_yellow(led_yellow)
  );

  // Expected trace: item i occupies cycles i*P+1..(i+1)*P after the start edge;
  // read in its first cycle, LED lit from its third cycle for the on-time.
  task automatic run_playback(input string name, input int last, input bit spd,
                              input int disturb_k, input int abort_k);
    int on_t, p, n, t, reads, i, o;
    logic [11:0] exp;
    on_t = spd ? FAST : SLOW;
    p = 2 + on_t + GAPT;
    n = last + 1;
    t = n * p;
    reads = 0;
    @(negedge clk);
    last_index = 5'(last);
    speed = spd;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= t + 2; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      i = (k - 1) / p;
      o = (k - 1) % p;
      exp = '0;
      if (k <= t) begin
        exp[11] = 1'b1;
        if (o == 0) begin
          exp[9] = 1'b1;
          exp[8:4] = 5'(i);
        end
        if (o >= 2 && o < 2 + on_t) exp[3:0] = 4'(1 << mem[i]);
      end else if (k == t + 1) exp[11:10] = 2'b11;
      if (mem_rd) reads++;
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s cycle E0+%0d: {busy,done,rd,addr,leds} got %h expected %h", name, k, obs, exp);
      end
      if (k == abort_k) return;
      if (k == disturb_k) begin
        start = 1'b1;
        speed = ~spd;
        last_index = ~5'(last);
      end else if (k == disturb_k + 1) start = 1'b0;
    end
    tests++;
    if (reads != n) begin
      fails++;
      $display("FAIL %s read_count: got %0d expected %0d", name, reads, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (obs !== 12'h000) begin fails++; $display("FAIL reset_hold: got %h expected 000", obs); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 12'h000) begin fails++; $display("FAIL reset_idle: got %h expected 000", obs); end
    all_leds = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 12'h00f) begin fails++; $display("FAIL idle_all_leds: got %h expected 00f", obs); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 12'h000) begin fails++; $display("FAIL reset_masks_all_leds: got %h expected 000", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    all_leds = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_playback("fast_4_items", 3, 1'b1, 0, 0);
  endtask

  task automatic test_single_slow();
    run_playback("slow_single", 0, 1'b0, 0, 0);
  endtask

  task automatic test_full_length();
    run_playback("full_32", 31, 1'b1, 0, 0);
  endtask

  task automatic test_restart_ignored();
    run_playback("restart_ignored", 3, 1'b1, 11, 0);
  endtask

  task automatic test_reset_mid();
    run_playback("pre_reset", 3, 1'b1, 0, 20);
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 12'h000) begin fails++; $display("FAIL mid_reset_outputs: got %h expected 000", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_playback("replay_after_reset", 1, 1'b1, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 32; j++) mem[j] = 2'($urandom);
      run_playback($sformatf("random_%0d", r), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 0, 0);
    end
    for (int j = 0; j < 32; j++) mem[j] = 2'(j);
  endtask

  initial begin
    for (int j = 0; j < 32; j++) mem[j] = 2'(j);
    test_reset();
    test_basic();
    test_single_slow();
    test_full_length();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
